// File: rtl/rmii_frame_tx.sv
// rmii_frame_tx: RMII transmit framer emitting preamble, SFD, payload, zero pad, CRC-32 FCS and inter-packet gap
module rmii_frame_tx #(
    parameter int MIN_PAYLOAD = 60,
    parameter int PAD_EN      = 1,
    parameter int IFG_CYCLES  = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       txen,
    output logic [1:0] txd,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;
    localparam logic [15:0] MIN_BYTES = 16'(MIN_PAYLOAD);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 2);
    state_t      state_q, state_d;
    logic [1:0]  dcnt_q, dcnt_d, txd_q, txd_d;
    logic [15:0] cnt_q, cnt_d, bcnt_q, bcnt_d, bcnt_inc;
    logic [7:0]  sh_q, sh_d;
    logic [31:0] crc_q, crc_d;
    logic        last_q, last_d, txen_q, txen_d, done_q, done_d, byte_end, take;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign byte_end   = dcnt_q == 2'd3;
    assign s_ready    = (state_q == SFD || state_q == DATA) && byte_end && !last_q;
    assign underrun   = s_ready && !s_valid;
    assign take       = s_ready && s_valid;
    assign bcnt_inc   = bcnt_q == 16'hFFFF ? bcnt_q : bcnt_q + 16'd1;
    assign txen       = txen_q;
    assign txd        = txd_q;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;

    always_comb begin
        state_d = state_q;
        dcnt_d  = (state_q inside {PRE, SFD, DATA, PAD}) ? dcnt_q + 2'd1 : dcnt_q;
        cnt_d   = cnt_q;
        bcnt_d  = take ? bcnt_inc : bcnt_q;
        last_d  = take ? s_last : last_q;
        sh_d    = take ? s_data : sh_q;
        crc_d   = (state_q inside {DATA, PAD}) ? crc_dibit(crc_q, txd_q) : crc_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (s_valid) begin
                state_d = PRE;
                dcnt_d  = 2'd0;
                cnt_d   = 16'd0;
                bcnt_d  = 16'd0;
                last_d  = 1'b0;
                crc_d   = '1;
            end
            PRE: if (byte_end) begin
                state_d = cnt_q == 16'd6 ? SFD : PRE;
                cnt_d   = cnt_q == 16'd6 ? 16'd0 : cnt_q + 16'd1;
            end
            SFD: if (byte_end) state_d = underrun ? IFG : DATA;
            DATA: if (byte_end) state_d = underrun ? IFG : !last_q ? DATA :
                                          (PAD_EN != 0 && bcnt_q < MIN_BYTES) ? PAD : FCS;
            PAD: if (byte_end) begin
                bcnt_d  = bcnt_inc;
                state_d = bcnt_inc >= MIN_BYTES ? FCS : PAD;
            end
            FCS: begin
                state_d = cnt_q == 16'd15 ? IFG : FCS;
                cnt_d   = cnt_q == 16'd15 ? 16'd0 : cnt_q + 16'd1;
                done_d  = cnt_q == 16'd15;
            end
            IFG: begin
                state_d = cnt_q == IFG_LAST ? IDLE : IFG;
                cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
        txen_d = state_d inside {PRE, SFD, DATA, PAD, FCS};
        txd_d  = state_d == DATA ? 2'(sh_d >> {dcnt_d, 1'b0}) :
                 state_d == FCS  ? 2'(~crc_d >> {cnt_d[3:0], 1'b0}) :
                 (state_d == SFD && dcnt_d == 2'd3) ? 2'b11 :
                 (state_d inside {PRE, SFD}) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            crc_q   <= '0;
            last_q  <= 1'b0;
            txen_q  <= 1'b0;
            txd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            crc_q   <= crc_d;
            last_q  <= last_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_rmii_frame_tx.sv
// tb_rmii_frame_tx: table-driven and directed checks of the RMII framer wire output against a byte-wise CRC-32 model
module tb_rmii_frame_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       use_nop = 1'b0;
    logic       p_rdy, p_en, p_busy, p_done, p_ur, n_rdy, n_en, n_busy, n_done, n_ur;
    logic [1:0] p_txd, n_txd;
    logic       rdy, m_en, m_busy, m_done, m_ur;
    logic [1:0] m_txd;
    int         total = 0;
    int         bad = 0;
    logic [7:0] sd [0:255];
    logic       sl [0:255];
    logic [7:0] ep [0:255];
    logic [1:0] dq [$];
    int         lens [$];
    int         gaps [$];
    int         run = 0, low = 0, txd_bad = 0, n_dn = 0, n_urun = 0;
    logic       seen = 1'b0, prev_en = 1'b0;

    typedef struct {
        logic        nop;
        int          n;
        int          kind;
        int          drop;
        int          len;
        int          done;
        int          urun;
        int          gap;
        logic [31:0] ref_fcs;
    } vec_t;
    vec_t vt [7];

    rmii_frame_tx #(.PAD_EN(1)) u_pad (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(p_rdy), .txen(p_en), .txd(p_txd), .busy(p_busy), .frame_done(p_done), .underrun(p_ur)
    );
    rmii_frame_tx #(.PAD_EN(0)) u_nop (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(n_rdy), .txen(n_en), .txd(n_txd), .busy(n_busy), .frame_done(n_done), .underrun(n_ur)
    );

    assign rdy    = use_nop ? n_rdy  : p_rdy;
    assign m_en   = use_nop ? n_en   : p_en;
    assign m_txd  = use_nop ? n_txd  : p_txd;
    assign m_busy = use_nop ? n_busy : p_busy;
    assign m_done = use_nop ? n_done : p_done;
    assign m_ur   = use_nop ? n_ur   : p_ur;

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (m_en) begin
            if (!prev_en && seen) gaps.push_back(low);
            if (!prev_en) run = 0;
            run++;
            dq.push_back(m_txd);
        end else begin
            if (prev_en) begin
                lens.push_back(run);
                seen = 1'b1;
                low = 0;
            end
            low++;
            if (m_txd != 2'b00) txd_bad++;
        end
        if (rst) seen = 1'b0;
        if (m_done) n_dn++;
        if (m_ur) n_urun++;
        prev_en = m_en;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int j);
        return kind == 0 ? 8'(32'h31 + j) : kind == 1 ? (j == 0 ? 8'hAB : 8'h00) : 8'(j * 7 + 3);
    endfunction

    function automatic logic [31:0] crc32(input int eo, input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, ep[eo + i]};
            for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    task automatic do_reset();
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input int n, input int stop_at, input logic hold);
        int   i;
        int   g;
        logic acc;
        i = 0;
        g = 0;
        s_valid = 1'b1;
        s_data = sd[0];
        s_last = sl[0];
        if (stop_at == 0) begin
            @(posedge clk);
            #1;
        end
        while (i < n && i != stop_at && g < 5000) begin
            @(negedge clk);
            acc = rdy && s_valid;
            @(posedge clk);
            #1;
            g++;
            if (acc) begin
                i++;
                if (i < n) begin
                    s_data = sd[i];
                    s_last = sl[i];
                end
            end
        end
        chk("drive bound", g < 5000, 1);
        if (i == stop_at || !hold) s_valid = 1'b0;
        else begin
            s_data = 8'h00;
            s_last = 1'b1;
        end
    endtask

    task automatic check_frame(input string nm, input int off, input int eo, input int nb,
                               input logic fcs, input logic [31:0] ref_fcs);
        int          bad_pre;
        int          bad_pay;
        int          need;
        logic [7:0]  b;
        logic [31:0] got;
        bad_pre = 0;
        bad_pay = 0;
        need = off + 32 + 4 * nb + (fcs ? 16 : 0);
        chk({nm, " captured"}, dq.size() >= need, 1);
        if (dq.size() < need) return;
        for (int k = 0; k < 32; k++) if (dq[off + k] != (k == 31 ? 2'b11 : 2'b01)) bad_pre++;
        chk({nm, " preamble"}, bad_pre, 0);
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 4; k++) b[2*k +: 2] = dq[off + 32 + 4 * j + k];
            if (b != ep[eo + j]) bad_pay++;
        end
        chk({nm, " payload"}, bad_pay, 0);
        if (fcs) begin
            for (int k = 0; k < 16; k++) got[2*k +: 2] = dq[off + 32 + 4 * nb + k];
            chk({nm, " fcs"}, got, crc32(eo, nb));
            if (ref_fcs != 0) chk({nm, " fcs ref"}, got, ref_fcs);
        end
    endtask

    initial begin
        int db, lb, gb, d0, u0, npad;
        string nm;
        vt[0] = '{1'b1,  9, 0, -1,  84, 1, 0, 48, 32'hCBF43926};
        vt[1] = '{1'b0,  1, 1, -1, 288, 1, 0, 48, 32'h0};
        vt[2] = '{1'b0, 64, 2, 10,  72, 0, 1, 48, 32'h0};
        vt[3] = '{1'b0, 61, 2, -1, 292, 1, 0, 48, 32'h0};
        vt[4] = '{1'b1,  1, 1, -1,  52, 1, 0, 48, 32'h0};
        vt[5] = '{1'b0, 60, 0, -1, 288, 1, 0, 48, 32'h0};
        vt[6] = '{1'b1, 64, 2,  0,  32, 0, 1, 48, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pad", {p_en, p_txd, p_rdy, p_busy, p_done, p_ur}, 0);
        chk("reset nop", {n_en, n_txd, n_rdy, n_busy, n_done, n_ur}, 0);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle %0d", c), {p_en, p_txd, p_rdy, p_busy, n_en, n_txd, n_rdy, n_busy}, 0);
        end

        for (int r = 0; r < 7; r++) begin
            nm = $sformatf("row%0d", r);
            do_reset();
            use_nop = vt[r].nop;
            npad = (vt[r].nop || vt[r].n >= 60) ? vt[r].n : 60;
            for (int j = 0; j < 256; j++) begin
                sd[j] = pat(vt[r].kind, j);
                sl[j] = j == vt[r].n - 1;
                ep[j] = j < vt[r].n ? pat(vt[r].kind, j) : 8'h00;
            end
            db = dq.size(); lb = lens.size(); gb = gaps.size(); d0 = n_dn; u0 = n_urun;
            drive(vt[r].n, vt[r].drop, 1'b1);
            if (vt[r].drop >= 0) begin
                for (int c = 0; c < 300 && n_urun == u0; c++) @(negedge clk);
                @(posedge clk);
                #1;
                s_valid = 1'b1;
                s_data = 8'h00;
                s_last = 1'b1;
            end
            for (int c = 0; c < 3000 && gaps.size() <= gb; c++) @(negedge clk);
            chk({nm, " gap seen"}, gaps.size() > gb, 1);
            chk({nm, " len"}, lens[lb], vt[r].len);
            chk({nm, " gap"}, gaps[gb], vt[r].gap);
            chk({nm, " done"}, n_dn - d0, vt[r].done);
            chk({nm, " underrun"}, n_urun - u0, vt[r].urun);
            check_frame(nm, db, 0, vt[r].drop >= 0 ? vt[r].drop : npad, vt[r].drop < 0, vt[r].ref_fcs);
        end

        do_reset();
        use_nop = 1'b0;
        for (int j = 0; j < 256; j++) begin
            sd[j] = pat(2, j);
            sl[j] = j == 59 || j == 119;
            ep[j] = pat(2, j);
        end
        db = dq.size(); lb = lens.size(); gb = gaps.size(); d0 = n_dn;
        drive(120, -1, 1'b0);
        for (int c = 0; c < 3000 && lens.size() < lb + 2; c++) @(negedge clk);
        chk("b2b frames", lens.size() >= lb + 2, 1);
        chk("b2b len0", lens[lb], 288);
        chk("b2b len1", lens[lb + 1], 288);
        chk("b2b gap", gaps[gb], 48);
        chk("b2b done", n_dn - d0, 2);
        check_frame("b2b f0", db, 0, 60, 1'b1, 32'h0);
        check_frame("b2b f1", db + 288, 60, 60, 1'b1, 32'h0);

        do_reset();
        for (int j = 0; j < 256; j++) begin
            sd[j] = pat(0, j);
            sl[j] = j == 63;
        end
        drive(64, 21, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst txen busy", {m_en, m_busy}, 0);
        @(posedge clk);
        #1;
        for (int j = 0; j < 256; j++) begin
            sd[j] = pat(2, j);
            sl[j] = j == 59;
            ep[j] = pat(2, j);
        end
        db = dq.size(); lb = lens.size(); d0 = n_dn;
        drive(60, -1, 1'b0);
        for (int c = 0; c < 3000 && lens.size() <= lb; c++) @(negedge clk);
        chk("postrst len", lens[lb], 288);
        chk("postrst done", n_dn - d0, 1);
        check_frame("postrst", db, 0, 60, 1'b1, 32'h0);
        chk("txd idle zero", txd_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rmii_frame_tx.md
Name: rmii_frame_tx

Overview:
- Ethernet RMII transmit framer for the 50 MHz Ethernet clock domain, one dibit per clock (100 Mb/s).
- Takes a byte stream (valid/ready/last) from the core's response path and drives eth_txen/eth_txd with a complete frame: preamble, SFD, payload, optional zero pad, and CRC-32 FCS.
- Enforces the inter-packet gap. It is the transmit counterpart of the RMII receive path (crsdv/rxd).

Parameters:
- MIN_PAYLOAD, 60, minimum bytes (payload+pad) before FCS when PAD_EN=1.
- PAD_EN, 1, 1 = zero-pad short frames to MIN_PAYLOAD; 0 = no padding.
- IFG_CYCLES, 48, idle clocks after FCS before the next frame may start (12 byte times).

Ports:
- clk  input  1  50 MHz RMII reference clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  8  payload byte.
- s_valid  input  1  s_data valid; once high must hold with stable data until accepted.
- s_last  input  1  marks final payload byte; qualified by s_valid.
- s_ready  output  1  byte accepted this cycle when s_valid && s_ready.
- txen  output  1  RMII transmit enable (registered).
- txd  output  2  RMII transmit dibit, bit-per-byte LSB first (registered).
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse, frame completed with FCS.
- underrun  output  1  one-cycle pulse, frame aborted for missing data.

Behaviour:
- Reset (rst high at clk edge): state IDLE, txen=0, txd=00, busy=0, frame_done=0, underrun=0, all counters and CRC cleared. Reset mid-frame: txen low the following cycle; no FCS; no IFG.
- States: IDLE -> PREAMBLE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
- Per-byte dibit counter dcnt 0..3; each byte occupies 4 clocks, dibit k = byte[2k+1:2k].
- IDLE: s_ready=0. s_valid high moves to PREAMBLE. The byte is not consumed here. First preamble dibit appears on txen/txd the cycle after s_valid is sampled.
- PREAMBLE: 7 bytes 0x55, giving 28 clocks of txd=01, txen=1.
- SFD: 0xD5, giving dibits 01,01,01,11.
- s_ready combinational: 1 when (state==SFD or DATA) && dcnt==3 && last byte not yet accepted; otherwise 0.
- DATA: byte accepted at dcnt==3 is shifted out over the next 4 clocks.
- Underrun: s_ready=1 with s_valid=0 in DATA or at SFD dcnt==3.
  - underrun pulses that cycle.
  - txen drops the next cycle; the frame is truncated and no FCS is sent.
  - State goes to IFG.
- After s_last accepted and its 4 dibits sent:
  - If PAD_EN and bytes sent < MIN_PAYLOAD, go to PAD: 0x00 bytes until the count equals MIN_PAYLOAD.
  - Otherwise go to FCS.
- Byte count is 16 bits and saturates at 0xFFFF; no upper length limit is enforced.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated over every DATA and PAD dibit (not preamble/SFD). FCS = ~crc, sent as 16 dibits LSB first (byte0 = ~crc[7:0]).
- frame_done pulses in the first IFG cycle after the last FCS dibit.
- IFG: txen=0, txd=00 for IFG_CYCLES clocks, then IDLE. s_valid is ignored during IFG.
- txd=00 whenever txen=0.
- Frame length on wire (txen high): 32 + 4*Npad + 16 clocks, where Npad = max(N, MIN_PAYLOAD) if PAD_EN, else N.
- Simultaneous s_last and underrun cannot occur (underrun requires s_valid=0).

Test Plan:
- Reset with s_valid=0 -> txen=0, txd=00, s_ready=0, busy=0 for 20 cycles.
- PAD_EN=0, payload ASCII "123456789" (0x31..0x39) -> txen high exactly 32+36+16=84 clocks. Wire shows 28×01, then 01,01,01,11, then payload, then FCS bytes 26 39 F4 CB. frame_done pulses once; no next txen for 48 clocks.
- PAD_EN=1, single byte 0xAB with s_last -> 60 payload bytes on wire (0xAB + 59×0x00), txen high 32+240+16=288 clocks, FCS matches reference CRC of those 60 bytes.
- 64-byte payload with s_valid dropped for 1 cycle at byte 10's ready slot -> underrun pulse, txen low next cycle, no FCS, frame_done never pulses, 48 idle clocks, then IDLE.
- Two back-to-back 60-byte frames with s_valid held high -> exactly 48 clocks of txen=0 between frames; both FCS correct.
- rst asserted during DATA byte 20 -> txen=0 and busy=0 next cycle. A new frame started 1 cycle after rst release begins with preamble and has correct FCS.
